scene_draw_ctrl: RTL

Frame-draw sequencer that sits directly downstream of the pet status datapath. On each frame tick it latches the status flags (hungry, bored, dirty, sick, dying, deceased) and streams pixels to the VGA adapter: background, then pet, then one status bubble; or only the end screen when the pet is deceased. It addresses the shared sprite ROM bank through a select/address pair with fixed 1-cycle read latency.

---
 rtl/scene_draw_ctrl.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/scene_draw_ctrl.sv
// scene_draw_ctrl
// Frame-draw sequencer between the pet status datapath and the VGA adapter.
// On a frame_tick it latches the status flags and streams pixels: a full
// background pass, then the pet sprite, then at most one status bubble.
// When the pet is deceased it draws only the full-screen end screen.
//
// Ports
//   clk            system clock (single domain)
//   reset          synchronous, active-high
//   frame_tick     single-cycle frame start request
//   hungry, bored, dirty, sick, dying, deceased   status flags
//   sprite_sel     ROM select (0 bg, 1 end, 2 pet, 3..7 bubbles)
//   sprite_addr    linear ROM address, row*W+col
//   sprite_colour  ROM data, valid one cycle after sprite_addr
//   x, y, colour   pixel to the VGA adapter
//   plot           pixel write strobe
//   busy           frame in progress
//   done           one-cycle pulse at frame end
//   overrun        sticky: frame_tick seen while busy
//   dbgState       current FSM state (0 IDLE,1 BG,2 END,3 PET,4 BBL,5 FIN)
//
// Optional feature: define SCENE_DRAW_TRANSP_EN to suppress plot for
// TRANSP_COLOUR pixels in the PET and BBL passes.
//
// Pixel stream: plot acts as a valid strobe qualifying x/y/colour for one
// cycle; there is no ready, the adapter must accept every strobed pixel.
module scene_draw_ctrl #(
    parameter logic [7:0]          X_SCREEN_PIXELS = 8'd160,
    parameter logic [6:0]          Y_SCREEN_PIXELS = 7'd120,
    parameter logic [7:0]          PET_X           = 8'd64,
    parameter logic [6:0]          PET_Y           = 7'd48,
    parameter int                  PET_W           = 32,
    parameter int                  PET_H           = 32,
    parameter logic [7:0]          BBL_X           = 8'd96,
    parameter logic [6:0]          BBL_Y           = 7'd24,
    parameter int                  BBL_W           = 24,
    parameter int                  BBL_H           = 16,
    parameter int                  COLOUR_W        = 3,
    parameter logic [COLOUR_W-1:0] TRANSP_COLOUR   = 3'b101
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                frame_tick,
    input  logic                hungry,
    input  logic                bored,
    input  logic                dirty,
    input  logic                sick,
    input  logic                dying,
    input  logic                deceased,
    output logic [2:0]          sprite_sel,
    output logic [14:0]         sprite_addr,
    input  logic [COLOUR_W-1:0] sprite_colour,
    output logic [7:0]          x,
    output logic [6:0]          y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot,
    output logic                busy,
    output logic                done,
    output logic                overrun,
    output logic [2:0]          dbgState
);

`ifdef SCENE_DRAW_TRANSP_EN
    localparam bit TRANSP_EN = 1'b1;
`else
    localparam bit TRANSP_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        BG   = 3'd1,
        END  = 3'd2,
        PET  = 3'd3,
        BBL  = 3'd4,
        FIN  = 3'd5
    } state_t;

    state_t      state, stateNext;

    logic [7:0]  col;
    logic [6:0]  row;
    logic [14:0] addrCnt;
    logic        drain;      // last address of the pass issued; waiting for its pixel
    logic        pxValid;    // an address was issued last cycle
    logic        pxTransp;   // that address belonged to a PET or BBL pass
    logic [2:0]  bblSelQ;
    logic        bblAnyQ;
    logic [2:0]  bblSelD;
    logic        bblAnyD;

    logic [7:0]  passW;
    logic [6:0]  passH;
    logic [7:0]  passX;
    logic [6:0]  passY;
    logic        lastPix;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    // Next-state logic
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: if (frame_tick) stateNext = deceased ? END : BG;
            BG:   if (drain) stateNext = PET;
            END:  if (drain) stateNext = FIN;
            PET:  if (drain) stateNext = bblAnyQ ? BBL : FIN;
            BBL:  if (drain) stateNext = FIN;
            FIN:  stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Output / pass-geometry logic
    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        sprite_sel = 3'd0;
        passW      = X_SCREEN_PIXELS;
        passH      = Y_SCREEN_PIXELS;
        passX      = 8'd0;
        passY      = 7'd0;
        case (state)
            BG:  busy = 1'b1;
            END: begin
                busy       = 1'b1;
                sprite_sel = 3'd1;
            end
            PET: begin
                busy       = 1'b1;
                sprite_sel = 3'd2;
                passW      = 8'(PET_W);
                passH      = 7'(PET_H);
                passX      = PET_X;
                passY      = PET_Y;
            end
            BBL: begin
                busy       = 1'b1;
                sprite_sel = bblSelQ;
                passW      = 8'(BBL_W);
                passH      = 7'(BBL_H);
                passX      = BBL_X;
                passY      = BBL_Y;
            end
            FIN: done = 1'b1;
            default: ;
        endcase
    end

    // Bubble priority: dying > sick > hungry > dirty > bored
    always_comb begin
        bblSelD = 3'd0;
        if (dying)       bblSelD = 3'd7;
        else if (sick)   bblSelD = 3'd6;
        else if (hungry) bblSelD = 3'd3;
        else if (dirty)  bblSelD = 3'd5;
        else if (bored)  bblSelD = 3'd4;
    end
    assign bblAnyD = dying | sick | hungry | dirty | bored;

    assign lastPix = (col == passW - 8'd1) && (row == passH - 7'd1);

    // Scan datapath: counters, pixel alignment stage, flag latch, overrun
    always_ff @(posedge clk) begin
        if (reset) begin
            col      <= 8'd0;
            row      <= 7'd0;
            addrCnt  <= 15'd0;
            drain    <= 1'b0;
            pxValid  <= 1'b0;
            pxTransp <= 1'b0;
            x        <= 8'd0;
            y        <= 7'd0;
            overrun  <= 1'b0;
            bblSelQ  <= 3'd0;
            bblAnyQ  <= 1'b0;
        end else begin
            pxValid  <= busy && !drain;
            pxTransp <= (state == PET) || (state == BBL);
            if (busy && !drain) begin
                x <= passX + col;
                y <= passY + row;
            end
            if (frame_tick && busy) overrun <= 1'b1;
            if (state == IDLE && frame_tick) begin
                bblSelQ <= bblSelD;
                bblAnyQ <= bblAnyD;
            end
            // Every state change starts the next pass from address 0.
            if (stateNext != state) begin
                col     <= 8'd0;
                row     <= 7'd0;
                addrCnt <= 15'd0;
                drain   <= 1'b0;
            end else if (busy && !drain) begin
                if (lastPix) begin
                    drain <= 1'b1;
                end else begin
                    addrCnt <= addrCnt + 15'd1;
                    if (col == passW - 8'd1) begin
                        col <= 8'd0;
                        row <= row + 7'd1;
                    end else begin
                        col <= col + 8'd1;
                    end
                end
            end
        end
    end

    assign sprite_addr = addrCnt;
    assign colour      = pxValid ? sprite_colour : '0;
    assign plot        = pxValid && !(TRANSP_EN && pxTransp && (sprite_colour == TRANSP_COLOUR));
    assign dbgState    = state;

endmodule
